// File: rtl/bf_seq_pkg.sv
// Shared types and helpers for the Bit Fusion array sequencer: FSM state encoding,
// legal precision encodings and the array result-latency calculation.
package bf_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD_W = 3'd1,
      ST_STREAM = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_DONE   = 3'd4
   } bf_seq_state_t;

   localparam logic [3:0] WIDTH_1 = 4'd1;
   localparam logic [3:0] WIDTH_2 = 4'd2;
   localparam logic [3:0] WIDTH_4 = 4'd4;
   localparam logic [3:0] WIDTH_8 = 4'd8;

   // Buffer read (1) + wrapper registers + skew across the array columns.
   function automatic int bf_seq_lat(input int array_size, input int pipe_lat);
      return 1 + pipe_lat + (array_size - 1);
   endfunction

   function automatic logic bf_width_legal(input logic [3:0] w);
      return (w == WIDTH_1) || (w == WIDTH_2) || (w == WIDTH_4) || (w == WIDTH_8);
   endfunction

endpackage

// File: rtl/bf_valid_delay.sv
// Fixed-depth single-bit shift register; turns an input-buffer read strobe into the
// matching psum-valid strobe DEPTH cycles later.
module bf_valid_delay #(
   parameter int DEPTH = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [DEPTH-1:0] sr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr <= '0;
      end else begin
         sr[0] <= d;
         for (int i = 1; i < DEPTH; i++) begin
            sr[i] <= sr[i-1];
         end
      end
   end

   assign q = sr[DEPTH-1];

endmodule

// File: rtl/bf_array_sequencer.sv
// Sequences one systolic-array pass: weight tile load, input streaming, psum drain.
// Optional BF_SEQ_PERF_CNT_EN adds perf_cycles (accept-to-done cycle count).
module bf_array_sequencer
   import bf_seq_pkg::*;
#(
   parameter int ARRAY_SIZE = 8,
   parameter int ADDR_W     = 10,
   parameter int VEC_CNT_W  = 16,
   parameter int PIPE_LAT   = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [3:0]           cmd_in_width,
   input  logic [3:0]           cmd_weight_width,
   input  logic                 cmd_s_in,
   input  logic                 cmd_s_weight,
   input  logic [VEC_CNT_W-1:0] cmd_num_vec,
   input  logic [ADDR_W-1:0]    cmd_w_base,
   input  logic [ADDR_W-1:0]    cmd_in_base,
   input  logic [ADDR_W-1:0]    cmd_out_base,
   output logic                 wbuf_rd_en,
   output logic [ADDR_W-1:0]    wbuf_rd_addr,
   output logic                 weight_load,
   output logic                 ibuf_rd_en,
   output logic [ADDR_W-1:0]    ibuf_rd_addr,
   output logic                 obuf_wr_en,
   output logic [ADDR_W-1:0]    obuf_wr_addr,
   output logic [3:0]           in_width,
   output logic [3:0]           weight_width,
   output logic                 s_in,
   output logic                 s_weight,
   output logic                 busy,
   output logic                 done,
`ifdef BF_SEQ_PERF_CNT_EN
   output logic [31:0]          perf_cycles,
`endif
   output logic [2:0]           state_dbg,
   output logic                 err
);

   localparam int LAT = bf_seq_lat(ARRAY_SIZE, PIPE_LAT);
   localparam logic [VEC_CNT_W-1:0] LAST_W = VEC_CNT_W'(ARRAY_SIZE - 1);

   bf_seq_state_t        state, state_next;
   logic [VEC_CNT_W-1:0] idx, wr_cnt, wr_cnt_next, num_vec_q;
   logic [ADDR_W-1:0]    w_base_q, in_base_q, out_base_q;
   logic                 accept, legal, idx_clr, idx_inc;

   // Command handshake: a command transfers on any cycle where cmd_valid and
   // cmd_ready are both high; cmd_ready is high only in IDLE and never depends
   // on cmd_valid, so a held command simply waits for the sequencer to go idle.
   assign accept      = cmd_valid && cmd_ready;
   assign legal       = bf_width_legal(cmd_in_width) && bf_width_legal(cmd_weight_width);
   assign wr_cnt_next = wr_cnt + VEC_CNT_W'(obuf_wr_en);
   assign state_dbg   = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      cmd_ready  = 1'b0;
      wbuf_rd_en = 1'b0;
      ibuf_rd_en = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      idx_clr    = 1'b0;
      idx_inc    = 1'b0;
      case (state)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (accept && legal) state_next = ST_LOAD_W;
         end
         ST_LOAD_W: begin
            wbuf_rd_en = 1'b1;
            if (idx == LAST_W) begin
               idx_clr    = 1'b1;
               state_next = (num_vec_q == '0) ? ST_DRAIN : ST_STREAM;
            end else begin
               idx_inc = 1'b1;
            end
         end
         ST_STREAM: begin
            ibuf_rd_en = 1'b1;
            if (idx == num_vec_q - VEC_CNT_W'(1)) begin
               idx_clr    = 1'b1;
               state_next = ST_DRAIN;
            end else begin
               idx_inc = 1'b1;
            end
         end
         ST_DRAIN: begin
            // Looking at the count including this cycle's write lets done
            // follow the final write by exactly one cycle.
            if (wr_cnt_next == num_vec_q) state_next = ST_DONE;
         end
         ST_DONE: begin
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            busy       = 1'b0;
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx          <= '0;
         wr_cnt       <= '0;
         num_vec_q    <= '0;
         w_base_q     <= '0;
         in_base_q    <= '0;
         out_base_q   <= '0;
         in_width     <= '0;
         weight_width <= '0;
         s_in         <= 1'b0;
         s_weight     <= 1'b0;
         weight_load  <= 1'b0;
         err          <= 1'b0;
      end else begin
         weight_load <= wbuf_rd_en;
         err         <= accept && !legal;
         if (accept && legal) begin
            idx          <= '0;
            wr_cnt       <= '0;
            num_vec_q    <= cmd_num_vec;
            w_base_q     <= cmd_w_base;
            in_base_q    <= cmd_in_base;
            out_base_q   <= cmd_out_base;
            in_width     <= cmd_in_width;
            weight_width <= cmd_weight_width;
            s_in         <= cmd_s_in;
            s_weight     <= cmd_s_weight;
         end else begin
            wr_cnt <= wr_cnt_next;
            if (idx_clr)      idx <= '0;
            else if (idx_inc) idx <= idx + VEC_CNT_W'(1);
         end
      end
   end

   assign wbuf_rd_addr = wbuf_rd_en ? w_base_q + ADDR_W'(idx) : '0;
   assign ibuf_rd_addr = ibuf_rd_en ? in_base_q + ADDR_W'(idx) : '0;
   assign obuf_wr_addr = obuf_wr_en ? out_base_q + ADDR_W'(wr_cnt) : '0;

   bf_valid_delay #(
      .DEPTH(LAT)
   ) u_valid_delay (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (ibuf_rd_en),
      .q    (obuf_wr_en)
   );

`ifdef BF_SEQ_PERF_CNT_EN
   logic [31:0] run_cnt;

   // run_cnt already includes the accept cycle, so done adds only itself.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_cnt     <= '0;
         perf_cycles <= '0;
      end else begin
         if (accept && legal) run_cnt <= 32'd1;
         else if (busy)       run_cnt <= run_cnt + 32'd1;
         if (done) perf_cycles <= run_cnt + 32'd1;
      end
   end
`endif

endmodule
